// File: rtl/alu_issue_stage.sv
// alu_issue_stage: single-entry issue register between RV32I decode and the ALU.
// It decodes the integer register-register, register-immediate, LUI and AUIPC
// instructions into an ALU operation plus two operands, and holds the result
// until the ALU/writeback side accepts it.
//
// Ports
//   clk_i, rst_i                 clock; synchronous active-high reset
//   in_valid_i / in_ready_o      upstream handshake (in_ready_o is combinational)
//   instr_i, pc_i                instruction word and its address
//   rs1_data_i, rs2_data_i       register-file read values for instr_i
//   flush_i                      drop the held packet and any incoming one
//   out_valid_o / out_ready_i    downstream handshake
//   alu_op_o, val1_o, val2_o     ALU operation and operands
//   rd_addr_o, rd_we_o           destination register and write enable
//   illegal_o                    packet carries an unsupported encoding
module alu_issue_stage #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  logic [31:0]     instr_i,
  input  logic [XLEN-1:0] pc_i,
  input  logic [XLEN-1:0] rs1_data_i,
  input  logic [XLEN-1:0] rs2_data_i,
  input  logic            flush_i,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic [3:0]      alu_op_o,
  output logic [XLEN-1:0] val1_o,
  output logic [XLEN-1:0] val2_o,
  output logic [4:0]      rd_addr_o,
  output logic            rd_we_o,
  output logic            illegal_o
);

  typedef enum logic [3:0] {
    AluAdd  = 4'b0000,
    AluSub  = 4'b0001,
    AluAnd  = 4'b0010,
    AluOr   = 4'b0011,
    AluXor  = 4'b0100,
    AluSll  = 4'b0101,
    AluSrl  = 4'b0110,
    AluSra  = 4'b0111,
    AluSlt  = 4'b1000,
    AluSltu = 4'b1001
  } alu_op_e;

  localparam logic [6:0] OpcOp    = 7'b0110011;
  localparam logic [6:0] OpcOpImm = 7'b0010011;
  localparam logic [6:0] OpcLui   = 7'b0110111;
  localparam logic [6:0] OpcAuipc = 7'b0010111;
  localparam logic [6:0] F7Zero   = 7'b0000000;
  localparam logic [6:0] F7Alt    = 7'b0100000;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic [4:0] rd;

  assign opcode = instr_i[6:0];
  assign funct3 = instr_i[14:12];
  assign funct7 = instr_i[31:25];
  assign rd     = instr_i[11:7];

  alu_op_e         dec_op;
  logic [XLEN-1:0] dec_v1;
  logic [XLEN-1:0] dec_v2;
  logic            dec_ill;

  // Decode purely from the current inputs; the result is frozen at capture.
  always_comb begin
    dec_op  = AluAdd;
    dec_v1  = rs1_data_i;
    dec_v2  = '0;
    dec_ill = 1'b0;
    unique case (opcode)
      OpcOp: begin
        dec_v2 = rs2_data_i;
        if (funct7 == F7Zero) begin
          case (funct3)
            3'b000:  dec_op = AluAdd;
            3'b001:  dec_op = AluSll;
            3'b010:  dec_op = AluSlt;
            3'b011:  dec_op = AluSltu;
            3'b100:  dec_op = AluXor;
            3'b101:  dec_op = AluSrl;
            3'b110:  dec_op = AluOr;
            default: dec_op = AluAnd;
          endcase
        end else if (funct7 == F7Alt && funct3 == 3'b000) begin
          dec_op = AluSub;
        end else if (funct7 == F7Alt && funct3 == 3'b101) begin
          dec_op = AluSra;
        end else begin
          dec_ill = 1'b1;
        end
      end
      OpcOpImm: begin
        dec_v2 = {{(XLEN-12){instr_i[31]}}, instr_i[31:20]};
        case (funct3)
          3'b000: dec_op = AluAdd;
          3'b010: dec_op = AluSlt;
          3'b011: dec_op = AluSltu;
          3'b100: dec_op = AluXor;
          3'b110: dec_op = AluOr;
          3'b111: dec_op = AluAnd;
          3'b001: begin
            dec_op  = AluSll;
            dec_v2  = {{(XLEN-5){1'b0}}, instr_i[24:20]};
            dec_ill = (funct7 != F7Zero);
          end
          default: begin
            dec_v2 = {{(XLEN-5){1'b0}}, instr_i[24:20]};
            if (funct7 == F7Zero) begin
              dec_op = AluSrl;
            end else if (funct7 == F7Alt) begin
              dec_op = AluSra;
            end else begin
              dec_ill = 1'b1;
            end
          end
        endcase
      end
      OpcLui: begin
        dec_v1 = '0;
        dec_v2 = {instr_i[31:12], 12'b0};
      end
      OpcAuipc: begin
        dec_v1 = pc_i;
        dec_v2 = {instr_i[31:12], 12'b0};
      end
      default: dec_ill = 1'b1;
    endcase
    // Illegal packets carry a neutral payload so the ALU never sees stale data.
    if (dec_ill) begin
      dec_op = AluAdd;
      dec_v1 = '0;
      dec_v2 = '0;
    end
  end

  logic            valid_q, valid_d;
  logic [3:0]      op_q, op_d;
  logic [XLEN-1:0] v1_q, v1_d;
  logic [XLEN-1:0] v2_q, v2_d;
  logic [4:0]      rd_q, rd_d;
  logic            we_q, we_d;
  logic            ill_q, ill_d;
  logic            capture;

  assign in_ready_o = !valid_q || out_ready_i;
  assign capture    = in_valid_i && in_ready_o && !flush_i;

  always_comb begin
    valid_d = valid_q;
    op_d    = op_q;
    v1_d    = v1_q;
    v2_d    = v2_q;
    rd_d    = rd_q;
    we_d    = we_q;
    ill_d   = ill_q;
    if (flush_i) begin
      valid_d = 1'b0;
    end else if (capture) begin
      valid_d = 1'b1;
      op_d    = dec_op;
      v1_d    = dec_v1;
      v2_d    = dec_v2;
      rd_d    = rd;
      we_d    = !dec_ill && (rd != 5'd0);
      ill_d   = dec_ill;
    end else if (out_ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      op_q    <= 4'b0000;
      v1_q    <= '0;
      v2_q    <= '0;
      rd_q    <= 5'd0;
      we_q    <= 1'b0;
      ill_q   <= 1'b0;
    end else begin
      valid_q <= valid_d;
      op_q    <= op_d;
      v1_q    <= v1_d;
      v2_q    <= v2_d;
      rd_q    <= rd_d;
      we_q    <= we_d;
      ill_q   <= ill_d;
    end
  end

  assign out_valid_o = valid_q;
  assign alu_op_o    = op_q;
  assign val1_o      = v1_q;
  assign val2_o      = v2_q;
  assign rd_addr_o   = rd_q;
  assign rd_we_o     = we_q;
  assign illegal_o   = ill_q;

endmodule

// File: doc/alu_issue_stage.md
ALU_ISSUE_STAGE -- requirements
Module: alu_issue_stage

Interface
REQ-001 Parameter XLEN, default 32, operand width; only 32 is supported.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 in_valid  input  1  upstream presents an instruction this cycle.
REQ-005 in_ready  output  1  stage can accept an instruction this cycle.
REQ-006 instr  input  32  RV32I instruction word.
REQ-007 pc  input  32  address of instr.
REQ-008 rs1_data, rs2_data  input  32 each  register-file read values for instr.
REQ-009 flush  input  1  discard held and incoming instruction.
REQ-010 out_valid  output  1  registered outputs hold a valid issue packet.
REQ-011 out_ready  input  1  ALU/writeback consumes the packet this cycle.
REQ-012 ALU_op  output  4  operation code to the ALU.
REQ-013 val1, val2  output  32 each  ALU operands.
REQ-014 rd_addr  output  5  destination register; rd_we  output  1  write enable.
REQ-015 illegal  output  1  packet is an unsupported encoding.

Function
REQ-016 The stage SHALL be a single-entry pipeline register: in_ready = !out_valid | out_ready, combinational.
REQ-017 Capture SHALL occur when in_valid & in_ready & !flush; outputs update the following edge (latency 1 cycle).
REQ-018 When out_valid & !out_ready, all outputs SHALL remain bit-stable.
REQ-019 When out_valid & out_ready & no capture, out_valid SHALL clear next cycle; capture and drain in the same cycle SHALL give back-to-back packets with no bubble.
REQ-020 flush SHALL clear out_valid next cycle and drop any coincident input; flush has priority over capture.
REQ-021 ALU_op encoding SHALL be: ADD 0000, SUB 0001, AND 0010, OR 0011, XOR 0100, SLL 0101, SRL 0110, SRA 0111, SLT 1000, SLTU 1001.
REQ-022 OP (0110011): val1=rs1_data, val2=rs2_data; funct7 0100000 legal only with funct3 000 (SUB) or 101 (SRA); any other funct7 than 0000000 SHALL be illegal.
REQ-023 OP-IMM (0010011): val1=rs1_data, val2=sign-extended imm[11:0]; SUBI does not exist (funct3 000 is always ADD).
REQ-024 Shift-immediates: val2={27'b0, instr[24:20]}; SLLI needs funct7 0000000; SRLI/SRAI need funct7 0000000/0100000, else illegal.
REQ-025 LUI (0110111): ALU_op ADD, val1=0, val2={instr[31:12],12'b0}.
REQ-026 AUIPC (0010111): ALU_op ADD, val1=pc, val2={instr[31:12],12'b0}.
REQ-027 Any other opcode SHALL set illegal=1, rd_we=0, ALU_op=0000, val1=val2=0, still out_valid=1.
REQ-028 rd_addr=instr[11:7] always; rd_we=1 only for legal packets with rd_addr != 0.
REQ-029 Decode SHALL be fully determined by the captured cycle's inputs; no dependence on later rs1/rs2 changes.

Reset
REQ-030 On rst, next edge: out_valid=0, ALU_op=0000, val1=val2=0, rd_addr=0, rd_we=0, illegal=0.
REQ-031 rst SHALL override capture, flush and backpressure; a held packet is discarded.
REQ-032 While rst is high, in_ready SHALL evaluate as 1 (out_valid=0) but no capture occurs.

Verification
REQ-033 ADDI x1,x0,-1: instr 0xFFF00093, rs1_data=0 -> next cycle out_valid=1, ALU_op=0000, val1=0, val2=0xFFFFFFFF, rd_addr=1, rd_we=1.
REQ-034 SUB x3,x1,x2: instr 0x402081B3, rs1_data=5, rs2_data=3 -> ALU_op=0001, val1=5, val2=3, rd_addr=3, illegal=0.
REQ-035 SRAI x5,x6,4: instr 0x40435293, rs1_data=0x80000000 -> ALU_op=0111, val1=0x80000000, val2=4; same with funct7 0100000 on SLLI (0x40431293) -> illegal=1, rd_we=0.
REQ-036 LUI x7,0x12345: instr 0x123453B7 -> ALU_op=0000, val1=0, val2=0x12345000; AUIPC with pc=0x100 -> val1=0x100.
REQ-037 Backpressure: packet valid, out_ready=0 for 3 cycles -> in_ready=0, outputs stable; out_ready=1 with new in_valid -> next packet appears next cycle, no bubble.
REQ-038 flush with in_valid=1 and a held packet -> out_valid=0 next cycle; rst asserted mid-backpressure -> all outputs at reset values next cycle.
